// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch counter slice: FSM state encoding,
// BCD digit width and per-digit rollover limits, and the packed M:SS.t
// time record used for both the live count and the lap snapshot.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } sw_state_e;

  localparam logic [DIGIT_W-1:0] TENTHS_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_LO_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_HI_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_MAX    = 4'd9;

  typedef struct packed {
    logic [DIGIT_W-1:0] min;
    logic [DIGIT_W-1:0] sec_hi;
    logic [DIGIT_W-1:0] sec_lo;
    logic [DIGIT_W-1:0] tenths;
  } bcd_time_t;

endpackage

// File: rtl/stopwatch_counter_tick_sync.sv
// tick_sync: brings an asynchronous level into the clk domain through a
// SYNC_STAGES-deep flop chain, then turns its edges into a one-cycle tick.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   async_in - asynchronous level input
//   tick_out - one-cycle pulse per rising edge (or per edge when
//              TICK_RISE_ONLY = 0)
module tick_sync #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          TICK_RISE_ONLY = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_out = TICK_RISE_ONLY ? (sync_q[SYNC_STAGES-1] & ~hist_q)
                                   : (sync_q[SYNC_STAGES-1] ^ hist_q);

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: counts 100 ms ticks as BCD M:SS.t under start/stop,
// clear and lap control, and drives the display-digit inputs of the scanner.
// Ports:
//   clk, rst_n               - system clock, asynchronous active-low reset
//   tick_clk_in              - divided 100 ms square wave (asynchronous)
//   start_stop, clear, lap   - single-cycle control pulses
//   running, frozen, wrap    - status (wrap is a one-cycle rollover pulse)
//   d_tenths .. d_min        - displayed digits (snapshot while frozen)
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          TICK_RISE_ONLY = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_clk_in,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               lap,
  output logic               running,
  output logic               frozen,
  output logic               wrap,
  output logic [DIGIT_W-1:0] d_tenths,
  output logic [DIGIT_W-1:0] d_sec_lo,
  output logic [DIGIT_W-1:0] d_sec_hi,
  output logic [DIGIT_W-1:0] d_min
);

  logic tick;

  tick_sync #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TICK_RISE_ONLY(TICK_RISE_ONLY)
  ) u_tick_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(tick_clk_in),
    .tick_out(tick)
  );

  sw_state_e state_q, state_d;
  bcd_time_t cnt_q, cnt_d;
  bcd_time_t snap_q, snap_d;
  bcd_time_t disp_q, disp_d;
  logic      frozen_q, frozen_d;
  logic      wrap_q, wrap_d;
  logic      running_q, running_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    frozen_d = frozen_q;
    wrap_d   = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      snap_d   = '0;
      frozen_d = 1'b0;
    end else begin
      // The tick is judged against the current state, so a RUN tick that
      // coincides with start_stop still counts before the move to PAUSE.
      if (state_q == RUN && tick) begin
        if (cnt_q.tenths != TENTHS_MAX) begin
          cnt_d.tenths = cnt_q.tenths + 4'd1;
        end else begin
          cnt_d.tenths = '0;
          if (cnt_q.sec_lo != SEC_LO_MAX) begin
            cnt_d.sec_lo = cnt_q.sec_lo + 4'd1;
          end else begin
            cnt_d.sec_lo = '0;
            if (cnt_q.sec_hi != SEC_HI_MAX) begin
              cnt_d.sec_hi = cnt_q.sec_hi + 4'd1;
            end else begin
              cnt_d.sec_hi = '0;
              if (cnt_q.min != MIN_MAX) begin
                cnt_d.min = cnt_q.min + 4'd1;
              end else begin
                cnt_d.min = '0;
                wrap_d    = 1'b1;
              end
            end
          end
        end
      end

      if (start_stop) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end else if (lap && state_q == RUN) begin
        if (frozen_q) begin
          frozen_d = 1'b0;
        end else begin
          // Snapshot takes the pre-increment count.
          snap_d   = cnt_q;
          frozen_d = 1'b1;
        end
      end
    end

    running_d = (state_d == RUN);
    // Display is selected from next-state values so it updates on the
    // same edge as the count it shows.
    disp_d    = frozen_d ? snap_d : cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      snap_q    <= '0;
      disp_q    <= '0;
      frozen_q  <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      disp_q    <= disp_d;
      frozen_q  <= frozen_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign running  = running_q;
  assign frozen   = frozen_q;
  assign wrap     = wrap_q;
  assign d_tenths = disp_q.tenths;
  assign d_sec_lo = disp_q.sec_lo;
  assign d_sec_hi = disp_q.sec_hi;
  assign d_min    = disp_q.min;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter (SYNC_STAGES=2, rising-edge ticks).
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_clk_in = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       running, frozen, wrap;
  logic [3:0] d_tenths, d_sec_lo, d_sec_hi, d_min;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_counter #(
    .SYNC_STAGES   (2),
    .TICK_RISE_ONLY(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_clk_in(tick_clk_in),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .running    (running),
    .frozen     (frozen),
    .wrap       (wrap),
    .d_tenths   (d_tenths),
    .d_sec_lo   (d_sec_lo),
    .d_sec_hi   (d_sec_hi),
    .d_min      (d_min)
  );

  wire [15:0] disp = {d_min, d_sec_hi, d_sec_lo, d_tenths};

  // Expected display for an elapsed count of n tenths (mod 10 minutes).
  function automatic logic [15:0] to_bcd(input int unsigned n);
    int unsigned m;
    m = n % 6000;
    to_bcd = {4'((m / 600) % 10), 4'((m / 100) % 6), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; cyc(1); lap = 1'b0;
  endtask

  // Fast tick: optional control pulses land in the cycle the internal tick
  // is high (third edge after the rise). Returns at the negedge just after
  // the counting edge, then drops the input long enough to rearm.
  task automatic fast_tick(input logic ss, input logic cl, input logic lp);
    tick_clk_in = 1'b1;
    cyc(2);
    start_stop = ss; clear = cl; lap = lp;
    cyc(1);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    tick_clk_in = 1'b0;
    cyc(3);
  endtask

  task automatic fast_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) fast_tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    cyc(3);
    check("rst_disp", disp, 16'h0000);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_frozen", {15'd0, frozen}, 16'd0);
    check("rst_wrap", {15'd0, wrap}, 16'd0);
    rst_n = 1'b1;
    cyc(2);

    // Start and 25 slow edges with 3-clk latency checks
    pulse_ss();
    check("start_running", {15'd0, running}, 16'd1);
    for (int unsigned i = 0; i < 25; i++) begin
      tick_clk_in = 1'b1;
      cyc(2);
      check("lat_before", disp, to_bcd(i));
      cyc(1);
      check("lat_after", disp, to_bcd(i + 1));
      cyc(47);
      tick_clk_in = 1'b0;
      cyc(50);
    end
    check("run25_disp", disp, 16'h0025);
    check("run25_running", {15'd0, running}, 16'd1);

    // Preload to 9:59.9, then rollover
    pulse_clear();
    check("clr_running", {15'd0, running}, 16'd0);
    pulse_ss();
    fast_ticks(5999);
    check("preload_disp", disp, 16'h9599);
    tick_clk_in = 1'b1;
    cyc(2);
    check("wrap_before", {15'd0, wrap}, 16'd0);
    cyc(1);
    check("wrap_disp", disp, 16'h0000);
    check("wrap_high", {15'd0, wrap}, 16'd1);
    check("wrap_running", {15'd0, running}, 16'd1);
    cyc(1);
    check("wrap_one_cycle", {15'd0, wrap}, 16'd0);
    tick_clk_in = 1'b0;
    cyc(3);

    // start_stop coinciding with tick
    pulse_clear();
    pulse_ss();
    fast_ticks(4);
    check("pre_ss_disp", disp, 16'h0004);
    fast_tick(1'b1, 1'b0, 1'b0);
    check("ss_tick_disp", disp, 16'h0005);
    check("ss_tick_paused", {15'd0, running}, 16'd0);
    fast_ticks(10);
    check("pause_hold", disp, 16'h0005);
    fast_tick(1'b1, 1'b0, 1'b0);
    check("resume_disp", disp, 16'h0005);
    check("resume_running", {15'd0, running}, 16'd1);

    // Lap freeze and release
    fast_ticks(7);
    check("pre_lap_disp", disp, 16'h0012);
    pulse_lap();
    check("lap_frozen", {15'd0, frozen}, 16'd1);
    fast_ticks(7);
    check("lap_hold", disp, 16'h0012);
    pulse_lap();
    check("lap_release_disp", disp, 16'h0019);
    check("lap_release_frozen", {15'd0, frozen}, 16'd0);
    pulse_ss();
    pulse_lap();
    check("pause_lap_frozen", {15'd0, frozen}, 16'd0);
    check("pause_lap_disp", disp, 16'h0019);

    // clear + start_stop + tick while frozen at 0:03.7
    pulse_ss();
    fast_ticks(18);
    check("pre_clr_disp", disp, 16'h0037);
    pulse_lap();
    check("pre_clr_frozen", {15'd0, frozen}, 16'd1);
    fast_tick(1'b1, 1'b1, 1'b0);
    check("clr_disp", disp, 16'h0000);
    check("clr_frozen", {15'd0, frozen}, 16'd0);
    check("clr_idle", {15'd0, running}, 16'd0);

    // Asynchronous reset mid-count
    pulse_ss();
    fast_ticks(3);
    check("pre_arst_disp", disp, 16'h0003);
    #1 rst_n = 1'b0;
    #1;
    check("arst_disp", disp, 16'h0000);
    check("arst_running", {15'd0, running}, 16'd0);
    #2 rst_n = 1'b1;
    cyc(1);
    fast_ticks(3);
    check("post_arst_idle", disp, 16'h0000);
    pulse_ss();
    fast_ticks(1);
    check("post_arst_run", disp, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
